// File: rtl/skeeball_game_ctrl.sv
// Game sequencer for the skeeball scorer: start, ball counting, optional inactivity
// timeout, settle-and-latch of the session high score, and one-shot hole sensor pulses.
module skeeball_game_ctrl #(
    parameter int NUM_BALLS     = 9,
    parameter int TIMEOUT       = 0,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sens0,
    input  logic       sens10,
    input  logic       sens20,
    input  logic       sens30,
    input  logic       sens40,
    input  logic       sens50,
    input  logic       sens100,
    input  logic [7:0] score,
    output logic       playstate,
    output logic       hit0,
    output logic       hit10,
    output logic       hit20,
    output logic       hit30,
    output logic       hit40,
    output logic       hit50,
    output logic       hit100,
    output logic [3:0] balls_left,
    output logic       game_over,
    output logic [7:0] high_score,
    output logic       new_high
);

    typedef enum logic [2:0] {IDLE, CLR, PLAY, SETTLE, DONE} state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state_q, state_d;
    logic            start_q;
    logic [6:0]      sens_q;
    logic            armed_q;
    logic [6:0]      hit_q, hit_d;
    logic [3:0]      balls_q, balls_d;
    logic [3:0]      settle_q, settle_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      high_q, high_d;
    logic            new_high_q, new_high_d;

    logic [6:0]      sens_raw;
    logic [6:0]      top_sel;
    logic            start_rise;
    logic            accept;

    assign sens_raw   = {sens100, sens50, sens40, sens30, sens20, sens10, sens0};
    assign start_rise = start & ~start_q;
    assign accept     = (state_q == PLAY) && armed_q && (sens_q != 7'b0);

    // Highest-value hole wins when several sensors are set together.
    always_comb begin
        top_sel = 7'b0;
        for (int i = 0; i < 7; i++) begin
            if (sens_q[i]) begin
                top_sel = 7'b1 << i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        balls_d    = balls_q;
        timer_d    = timer_q;
        settle_d   = settle_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        hit_d      = accept ? top_sel : 7'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) state_d = CLR;
            end
            CLR: begin
                balls_d    = 4'(NUM_BALLS);
                timer_d    = '0;
                new_high_d = 1'b0;
                state_d    = PLAY;
            end
            PLAY: begin
                settle_d = 4'd0;
                if (accept) begin
                    balls_d = balls_q - 1'b1;
                    timer_d = '0;
                    if (balls_q == 4'd1) state_d = SETTLE;
                end else if (TIMEOUT != 0) begin
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_d = SETTLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                // BCD digits compare correctly as plain unsigned bytes.
                if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
                    if (score > high_q) begin
                        high_d     = score;
                        new_high_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            DONE: begin
                if (start_rise) state_d = CLR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            sens_q     <= 7'b0;
            armed_q    <= 1'b1;
            hit_q      <= 7'b0;
            balls_q    <= 4'd0;
            settle_q   <= 4'd0;
            timer_q    <= '0;
            high_q     <= 8'h00;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            sens_q     <= sens_raw;
            // Re-arm only after every hole has read empty for a cycle.
            armed_q    <= (sens_q == 7'b0);
            hit_q      <= hit_d;
            balls_q    <= balls_d;
            settle_q   <= settle_d;
            timer_q    <= timer_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    assign playstate  = (state_q == PLAY) || (state_q == SETTLE) || (state_q == DONE);
    assign game_over  = (state_q == DONE);
    assign balls_left = balls_q;
    assign high_score = high_q;
    assign new_high   = new_high_q;
    assign {hit100, hit50, hit40, hit30, hit20, hit10, hit0} = hit_q;

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// Directed bench: dut1 uses default parameters, dut2 runs with a 20-cycle timeout.
// Hit pulses are matched against a queue of expected (code, cycle) pairs.
module tb_skeeball_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst2, st1, st2;
    logic [6:0] sens;
    logic [7:0] score;

    wire        ps1, ps2, go1, go2, nh1, nh2;
    wire [6:0]  h1, h2;
    wire [3:0]  bl1, bl2;
    wire [7:0]  hs1, hs2;

    skeeball_game_ctrl dut1 (
        .clk(clk), .reset(rst1), .start(st1),
        .sens0(sens[0]), .sens10(sens[1]), .sens20(sens[2]), .sens30(sens[3]),
        .sens40(sens[4]), .sens50(sens[5]), .sens100(sens[6]),
        .score(score), .playstate(ps1),
        .hit0(h1[0]), .hit10(h1[1]), .hit20(h1[2]), .hit30(h1[3]),
        .hit40(h1[4]), .hit50(h1[5]), .hit100(h1[6]),
        .balls_left(bl1), .game_over(go1), .high_score(hs1), .new_high(nh1)
    );

    skeeball_game_ctrl #(.TIMEOUT(20)) dut2 (
        .clk(clk), .reset(rst2), .start(st2),
        .sens0(sens[0]), .sens10(sens[1]), .sens20(sens[2]), .sens30(sens[3]),
        .sens40(sens[4]), .sens50(sens[5]), .sens100(sens[6]),
        .score(score), .playstate(ps2),
        .hit0(h2[0]), .hit10(h2[1]), .hit20(h2[2]), .hit30(h2[3]),
        .hit40(h2[4]), .hit50(h2[5]), .hit100(h2[6]),
        .balls_left(bl2), .game_over(go2), .high_score(hs2), .new_high(nh2)
    );

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic [13:0] exp_code[$];
    int          exp_cyc[$];
    logic [13:0] obs_code[$];
    int          obs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ({h2, h1} != 14'b0) begin
            obs_code.push_back({h2, h1});
            obs_cyc.push_back(cyc);
            $display("pulse cycle %0d dut1=%b dut2=%b", cyc, h1, h2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_hit(input logic [6:0] code, input bit sel);
        exp_code.push_back(sel ? {code, 7'b0} : {7'b0, code});
        exp_cyc.push_back(cyc + 2);
    endtask

    task automatic check_hits();
        while (exp_code.size() > 0) begin
            logic [13:0] ec;
            int          ecy;
            ec  = exp_code.pop_front();
            ecy = exp_cyc.pop_front();
            if (obs_code.size() == 0) begin
                chk("missing_hit", 32'(0), 32'(ec));
            end else begin
                chk("hit_code", 32'(obs_code.pop_front()), 32'(ec));
                chk("hit_cycle", obs_cyc.pop_front(), ecy);
            end
        end
        while (obs_code.size() > 0) begin
            chk("extra_hit", 32'(obs_code.pop_front()), 32'(0));
            void'(obs_cyc.pop_front());
        end
    endtask

    task automatic play_ball(input logic [6:0] code, input bit sel, input int hold);
        sens = code;
        push_hit(code, sel);
        repeat (hold) step();
        sens = 7'b0;
        repeat (2) step();
    endtask

    // Ninth ball: two SETTLE cycles after its pulse, then DONE.
    task automatic finish_game(input logic [7:0] exp_high, input logic exp_new);
        sens = 7'b1000000;
        push_hit(7'b1000000, 1'b0);
        repeat (3) step();
        chk("settle_not_done", go1, 1'b0);
        chk("settle_playstate", ps1, 1'b1);
        step();
        chk("done_game_over", go1, 1'b1);
        chk("done_high_score", hs1, exp_high);
        chk("done_new_high", nh1, exp_new);
        chk("done_playstate", ps1, 1'b1);
        chk("done_balls", bl1, 4'd0);
        sens = 7'b0;
        repeat (2) step();
        check_hits();
    endtask

    task automatic start_game1();
        st1 = 1'b1;
        step();
        chk("clr_playstate", ps1, 1'b0);
        st1 = 1'b0;
        step();
        chk("play_playstate", ps1, 1'b1);
        chk("play_balls", bl1, 4'd9);
        chk("play_game_over", go1, 1'b0);
        chk("play_new_high", nh1, 1'b0);
    endtask

    task automatic run_game(input logic [7:0] sc, input logic [7:0] exp_high, input logic exp_new);
        logic [6:0] code;
        start_game1();
        score = sc;
        for (int i = 0; i < 8; i++) begin
            code = 7'b1 << (i % 7);
            play_ball(code, 1'b0, 1 + (i % 3));
        end
        finish_game(exp_high, exp_new);
    endtask

    initial begin
        int p;
        rst1 = 1'b1; rst2 = 1'b1; st1 = 1'b0; st2 = 1'b0;
        sens = 7'b0; score = 8'h00;
        repeat (3) step();
        chk("rst_playstate", ps1, 1'b0);
        chk("rst_hits", h1, 7'b0);
        chk("rst_balls", bl1, 4'd0);
        chk("rst_game_over", go1, 1'b0);
        chk("rst_high_score", hs1, 8'h00);
        chk("rst_new_high", nh1, 1'b0);
        rst1 = 1'b0;
        step();
        chk("idle_playstate", ps1, 1'b0);

        // Game 1: long hold on 30, one low cycle, then 50.
        start_game1();
        sens = 7'b0001000;
        push_hit(7'b0001000, 1'b0);
        repeat (10) step();
        chk("held30_balls", bl1, 4'd8);
        sens = 7'b0;
        step();
        sens = 7'b0100000;
        push_hit(7'b0100000, 1'b0);
        repeat (3) step();
        sens = 7'b0;
        repeat (2) step();
        check_hits();
        chk("after50_balls", bl1, 4'd7);

        // 100 and 20 together, then 100 leaves while 20 stays.
        sens = 7'b1000100;
        push_hit(7'b1000000, 1'b0);
        repeat (3) step();
        sens = 7'b0000100;
        repeat (3) step();
        sens = 7'b0;
        repeat (2) step();
        check_hits();
        chk("pair_balls", bl1, 4'd6);

        st1 = 1'b1;
        step();
        chk("start_ignored_play", ps1, 1'b1);
        st1 = 1'b0;
        step();
        chk("start_ignored_balls", bl1, 4'd6);

        score = 8'h45;
        play_ball(7'b0000001, 1'b0, 1);
        play_ball(7'b0000010, 1'b0, 2);
        play_ball(7'b0010000, 1'b0, 1);
        play_ball(7'b0100000, 1'b0, 3);
        play_ball(7'b0000100, 1'b0, 1);
        finish_game(8'h45, 1'b1);

        run_game(8'h45, 8'h45, 1'b0);
        run_game(8'h38, 8'h45, 1'b0);
        run_game(8'h62, 8'h62, 1'b1);

        // Timeout instance: three hits, then silence.
        rst2 = 1'b0;
        step();
        st2 = 1'b1;
        step();
        chk("t_clr_playstate", ps2, 1'b0);
        st2 = 1'b0;
        step();
        chk("t_play_balls", bl2, 4'd9);
        play_ball(7'b0000010, 1'b1, 2);
        play_ball(7'b0001000, 1'b1, 2);
        p = cyc + 2;
        play_ball(7'b1000000, 1'b1, 2);
        for (int k = 0; k < 40 && cyc < p + 21; k++) step();
        chk("t_before_done", go2, 1'b0);
        chk("t_balls", bl2, 4'd6);
        chk("t_playstate", ps2, 1'b1);
        step();
        chk("t_done", go2, 1'b1);
        chk("t_done_balls", bl2, 4'd6);
        chk("t_high_score", hs2, 8'h62);
        chk("t_new_high", nh2, 1'b1);
        check_hits();

        // Reset in the middle of a game, landing on a pending pulse.
        st2 = 1'b1;
        step();
        st2 = 1'b0;
        step();
        chk("r_play_balls", bl2, 4'd9);
        play_ball(7'b0000010, 1'b1, 1);
        check_hits();
        chk("r_balls", bl2, 4'd8);
        sens = 7'b0100000;
        step();
        rst2 = 1'b1;
        step();
        chk("r_playstate", ps2, 1'b0);
        chk("r_hits", h2, 7'b0);
        chk("r_balls_reset", bl2, 4'd0);
        chk("r_game_over", go2, 1'b0);
        chk("r_high_score", hs2, 8'h00);
        chk("r_new_high", nh2, 1'b0);
        sens = 7'b0;
        rst2 = 1'b0;
        repeat (3) step();
        check_hits();
        chk("dut1_still_done", go1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
